// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b, SLICE bits per clock with the borrow
// carried between cycles. Start/done handshake, registered result.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = $clog2(NSLICE + 1);

    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("serial_subtractor: SLICE must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CW-1:0] CntLast = CW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic [SLICE-1:0] slice_d;
    logic [SLICE:0]   slice_brw;
    logic             slice_bout;
    logic [WIDTH-1:0] res_shifted;

    // Ripple-borrow slice over the low SLICE bits of the operand shift registers.
    always_comb begin
        slice_d      = '0;
        slice_brw    = '0;
        slice_brw[0] = bin_q;
        for (int i = 0; i < SLICE; i++) begin
            slice_d[i]       = a_sh_q[i] ^ b_sh_q[i] ^ slice_brw[i];
            slice_brw[i + 1] = (~a_sh_q[i] & b_sh_q[i]) |
                               (~(a_sh_q[i] ^ b_sh_q[i]) & slice_brw[i]);
        end
    end

    assign slice_bout = slice_brw[SLICE];

    // New slice enters at the top so that after NSLICE shifts bit 0 is the result LSB.
    assign res_shifted = (res_q >> SLICE) | (WIDTH'(slice_d) << (WIDTH - SLICE));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> SLICE;
                b_sh_d = b_sh_q >> SLICE;
                res_d  = res_shifted;
                bin_d  = slice_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    diff_d   = res_shifted;
                    borrow_d = slice_bout;
                    zero_d   = (res_shifted == '0);
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule
